mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (inst/data) arbiter onto a single-outstanding memory bus.
// Data wins by default; after four straight data grants with inst waiting, inst gets the bus.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state_q, state_d;
    logic        own_q, own_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        grant_d, grant_i;
    always_comb begin
        grant_d = (state_q == IDLE) && d_req && !(i_req && cnt_q == 3'd4);
        grant_i = (state_q == IDLE) && i_req && !grant_d;
        state_d = (state_q == IDLE) ? ((grant_d || grant_i) ? REQ : IDLE) :
                  (state_q == REQ)  ? (m_addr_ok ? WAIT : REQ) :
                                      (m_data_ok ? IDLE : WAIT);
        own_d   = grant_d ? 1'b1 : grant_i ? 1'b0 : own_q;
        wr_d    = grant_d ? d_wr : grant_i ? 1'b0 : wr_q;
        size_d  = grant_d ? d_size : grant_i ? 2'd2 : size_q;
        addr_d  = grant_d ? d_addr : grant_i ? i_addr : addr_q;
        wdata_d = grant_d ? d_wdata : grant_i ? 32'd0 : wdata_q;
        // Only data grants made while inst is waiting build up the fairness count.
        cnt_d   = grant_i ? 3'd0 : grant_d ? (i_req ? cnt_q + 3'd1 : 3'd0) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
    assign i_addr_ok = grant_i;
    assign d_addr_ok = grant_d;
    assign i_data_ok = (state_q == WAIT) && m_data_ok && !own_q;
    assign d_data_ok = (state_q == WAIT) && m_data_ok && own_q;
    assign rdata     = (i_data_ok || d_data_ok) ? m_rdata : 32'd0;
    assign m_req     = (state_q == REQ);
    assign m_wr      = m_req ? wr_q : 1'b0;
    assign m_size    = m_req ? size_q : 2'd0;
    assign m_addr    = m_req ? addr_q : 32'd0;
    assign m_wdata   = m_req ? wdata_q : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a scoreboard of expected read returns.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_addr_ok, i_data_ok;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata = '0;
    int n_cmp = 0;
    int n_err = 0;
    typedef struct {
        logic        dside;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .rdata(rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {63'd0, |{i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, m_req, m_wr,
                           m_size, m_addr, m_wdata, rdata}}, 64'd0);
    endtask

    // Entered in an IDLE cycle with requests already driven; m_data_ok is held high in REQ to prove it is ignored there.
    task automatic txn(input logic dside, input logic hold, input int aw, input int dw,
                       input logic [31:0] rd, input logic [31:0] ea, input logic ewr,
                       input logic [1:0] esz, input logic [31:0] ewd);
        exp_t e;
        @(negedge clk);
        chk("grant_i", {63'd0, i_addr_ok}, {63'd0, !dside});
        chk("grant_d", {63'd0, d_addr_ok}, {63'd0, dside});
        chk("idle_mreq", {63'd0, m_req}, 64'd0);
        e.dside = dside;
        e.rd    = rd;
        sb.push_back(e);
        for (int k = 0; k <= aw; k++) begin
            tick();
            if (k == 0 && !hold) begin
                if (dside) d_req = 1'b0;
                else i_req = 1'b0;
            end
            m_addr_ok = (k == aw);
            m_data_ok = 1'b1;
            m_rdata   = $urandom;
            @(negedge clk);
            chk("req_mreq", {63'd0, m_req}, 64'd1);
            chk("req_addr", {32'd0, m_addr}, {32'd0, ea});
            chk("req_wr", {63'd0, m_wr}, {63'd0, ewr});
            chk("req_size", {62'd0, m_size}, {62'd0, esz});
            chk("req_wdata", {32'd0, m_wdata}, {32'd0, ewd});
            chk("req_no_ok", {60'd0, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'd0);
            chk("req_rdata0", {32'd0, rdata}, 64'd0);
        end
        for (int k = 0; k <= dw; k++) begin
            tick();
            m_addr_ok = 1'b0;
            m_data_ok = (k == dw);
            m_rdata   = (k == dw) ? rd : $urandom;
            @(negedge clk);
            chk("wait_mreq", {63'd0, m_req}, 64'd0);
            if (k == dw) begin
                chk("sb_size", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("dok_i", {63'd0, i_data_ok}, {63'd0, !e.dside});
                    chk("dok_d", {63'd0, d_data_ok}, {63'd0, e.dside});
                    chk("rdata", {32'd0, rdata}, {32'd0, e.rd});
                end
            end else begin
                chk("wait_no_dok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
                chk("wait_rdata0", {32'd0, rdata}, 64'd0);
            end
        end
        tick();
        m_data_ok = 1'b0;
        m_addr_ok = 1'b0;
        m_rdata   = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dside;
        repeat (3) tick();
        @(negedge clk);
        chk_quiet("reset_outs");
        tick();
        rst = 1'b1;
        // Inst-only fetch with zero-wait bus
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        txn(1'b0, 1'b0, 0, 0, 32'h2401_0001, 32'hBFC0_0000, 1'b0, 2'd2, 32'd0);
        // Simultaneous requests: data first, inst in the next IDLE
        i_req   = 1'b1;
        i_addr  = 32'hBFC0_0004;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_size  = 2'd2;
        d_addr  = 32'h8000_1000;
        d_wdata = 32'hDEAD_BEEF;
        txn(1'b1, 1'b0, 0, 0, 32'h1111_2222, 32'h8000_1000, 1'b1, 2'd2, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 0, 0, 32'h3333_4444, 32'hBFC0_0004, 1'b0, 2'd2, 32'd0);
        // Fairness with both requests held: D D D D I D
        i_req   = 1'b1;
        i_addr  = 32'hBFC0_0100;
        d_req   = 1'b1;
        d_wr    = 1'b0;
        d_size  = 2'd1;
        d_addr  = 32'h8000_2002;
        d_wdata = 32'd0;
        for (int n = 0; n < 6; n++) begin
            dside = (n != 4);
            txn(dside, 1'b1, 0, 0, 32'h0000_1000 + n, dside ? d_addr : i_addr, 1'b0,
                dside ? 2'd1 : 2'd2, 32'd0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        // Bus stall: address phase 6 cycles, data 3 cycles late
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_size  = 2'd0;
        d_addr  = 32'h8000_3003;
        d_wdata = 32'h0000_00A5;
        txn(1'b1, 1'b0, 5, 3, 32'hCAFE_F00D, 32'h8000_3003, 1'b1, 2'd0, 32'h0000_00A5);
        m_data_ok = 1'b1;
        m_rdata   = 32'h5555_AAAA;
        @(negedge clk);
        chk("idle_mdok_ignored", {62'd0, i_data_ok, d_data_ok}, 64'd0);
        chk_quiet("idle_outs");
        tick();
        m_data_ok = 1'b0;
        // Reset while waiting on data
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_size = 2'd2;
        d_addr = 32'h8000_4000;
        @(negedge clk);
        chk("rst_grant", {63'd0, d_addr_ok}, 64'd1);
        tick();
        d_req     = 1'b0;
        m_addr_ok = 1'b1;
        @(negedge clk);
        chk("rst_req", {63'd0, m_req}, 64'd1);
        tick();
        m_addr_ok = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("rst_wait_mreq", {63'd0, m_req}, 64'd0);
        chk("rst_wait_no_dok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
        tick();
        rst       = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'h7777_8888;
        @(negedge clk);
        chk_quiet("rst_late_dok");
        tick();
        m_data_ok = 1'b0;
        @(negedge clk);
        chk_quiet("rst_after");
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
